// File: rtl/sync_pulse_rx.sv
// Receive stage for a toggle-to-pulse synchronizer: captures the held cross-domain bus on each pulse,
// presents it on valid/ready, returns a one-cycle ack, and counts pulses that arrive while full.
module sync_pulse_rx #(
  parameter int unsigned          DATA_W    = 16,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  parameter int unsigned          ACK_MODE  = 0,
  parameter int unsigned          DROP_W    = 4
) (
  input  logic              clkb,
  input  logic              clkb_rst_n,
  input  logic              p_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ack_t,
  output logic              err,
  input  logic              err_clr,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {S_IDLE, S_FULL} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic                r_ack;
  logic                r_err;
  logic [DROP_W-1:0]   r_cnt;

  state_t              w_state_nxt;
  logic                w_capture;
  logic                w_drop;
  logic                w_ack_nxt;
  logic                w_err_nxt;
  logic [DROP_W-1:0]   w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_ack_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (p_in) begin
          w_capture   = 1'b1;
          w_state_nxt = S_FULL;
          w_ack_nxt   = (ACK_MODE == 1);
        end
      end
      S_FULL: begin
        if (out_ready) begin
          // Transfer plus capture at one edge always yields exactly one ack, in either mode.
          if (p_in) begin
            w_capture = 1'b1;
            w_ack_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_ack_nxt   = (ACK_MODE == 0);
          end
        end else if (p_in) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_err_nxt = r_err;
    w_cnt_nxt = r_cnt;
    if (err_clr) begin
      // A drop coinciding with the clear is still recorded.
      w_err_nxt = w_drop;
      w_cnt_nxt = w_drop ? DROP_W'(1) : '0;
    end else if (w_drop) begin
      w_err_nxt = 1'b1;
      if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkb or negedge clkb_rst_n) begin
    if (!clkb_rst_n) begin
      r_state <= S_IDLE;
      r_data  <= RESET_VAL;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_data <= d_in;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_valid = (r_state == S_FULL);
  assign ack_t     = r_ack;
  assign err       = r_err;
  assign drop_cnt  = r_cnt;

endmodule

// File: tb/tb_sync_pulse_rx.sv
// Scoreboard bench for sync_pulse_rx: both ack modes run side by side on shared stimulus,
// compared against a word-level model of accept / transfer / drop behaviour.
module tb_sync_pulse_rx;

  logic        clkb = 1'b0;
  logic        clkb_rst_n = 1'b0;
  logic        p_in = 1'b0;
  logic [15:0] d_in = '0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic [15:0] od0, od1;
  logic        ov0, ov1, ack0, ack1, er0, er1;
  logic [3:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] q[$];
  bit          m_full = 0;
  bit          m_ack0 = 0, m_ack1 = 0, m_err = 0;
  int          m_cnt = 0;
  bit          mon_en = 0;

  always #5 clkb = ~clkb;

  sync_pulse_rx #(.DATA_W(16), .RESET_VAL(16'h0000), .ACK_MODE(0), .DROP_W(4)) dut0 (
    .clkb(clkb), .clkb_rst_n(clkb_rst_n), .p_in(p_in), .d_in(d_in),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .ack_t(ack0),
    .err(er0), .err_clr(err_clr), .drop_cnt(cnt0));

  sync_pulse_rx #(.DATA_W(16), .RESET_VAL(16'h5A5A), .ACK_MODE(1), .DROP_W(4)) dut1 (
    .clkb(clkb), .clkb_rst_n(clkb_rst_n), .p_in(p_in), .d_in(d_in),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .ack_t(ack1),
    .err(er1), .err_clr(err_clr), .drop_cnt(cnt1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_full = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit accepted, xfer, drop;
    if (!clkb_rst_n) begin
      model_reset();
      return;
    end
    accepted = p_in && (!m_full || out_ready);
    xfer     = m_full && out_ready;
    drop     = m_full && !out_ready && p_in;
    if (accepted) q.push_back(d_in);
    m_ack0 = xfer;
    m_ack1 = accepted;
    m_full = accepted || (m_full && !out_ready);
    if (err_clr) begin
      m_err = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_err = 1;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end
  endtask

  // One clock: drive inputs just after the edge, model the following edge.
  task automatic step(input bit rst, input bit p, input logic [15:0] d, input bit rdy, input bit clr);
    clkb_rst_n = rst; p_in = p; d_in = d; out_ready = rdy; err_clr = clr;
    if (!rst) model_reset();
    @(posedge clkb);
    model_edge();
    #1;
  endtask

  // Monitor: mid-cycle compare of all outputs; pop the scoreboard on each transfer.
  always @(negedge clkb) begin
    if (mon_en) begin
      chk("valid0", 32'(ov0), 32'(m_full));
      chk("valid1", 32'(ov1), 32'(m_full));
      chk("ack0", 32'(ack0), 32'(m_ack0));
      chk("ack1", 32'(ack1), 32'(m_ack1));
      chk("err0", 32'(er0), 32'(m_err));
      chk("err1", 32'(er1), 32'(m_err));
      chk("cnt0", 32'(cnt0), 32'(m_cnt));
      chk("cnt1", 32'(cnt1), 32'(m_cnt));
      if (ov0 || ov1) begin
        if (q.size() == 0) begin
          chk("sb_nonempty", 32'(q.size()), 32'd1);
        end else begin
          chk("data0", 32'(od0), 32'(q[0]));
          chk("data1", 32'(od1), 32'(q[0]));
          if (ov0 && out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset with p_in held high
    mon_en = 1;
    repeat (3) step(0, 1, 16'hDEAD, 0, 0);
    chk("rst_data0", 32'(od0), 32'h0000);
    chk("rst_data1", 32'(od1), 32'h5A5A);
    step(1, 1, 16'h0BAD, 0, 0);           // capture at first edge after release
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);

    // Single event, late ready
    step(1, 1, 16'hA5C3, 0, 0);
    repeat (3) step(1, 0, 16'hA5C3, 0, 0);
    step(1, 0, 16'hA5C3, 1, 0);
    repeat (2) step(1, 0, 16'h0, 0, 0);

    // Drop
    step(1, 1, 16'h1111, 0, 0);
    step(1, 0, 16'h1111, 0, 0);
    step(1, 1, 16'h2222, 0, 0);
    chk("drop_data", 32'(od0), 32'h1111);
    chk("drop_err", 32'(er0), 32'd1);
    chk("drop_cnt", 32'(cnt0), 32'd1);
    step(1, 0, 16'h0, 1, 1);
    step(1, 0, 16'h0, 0, 0);

    // Back-to-back transfers with capture
    step(1, 1, 16'h0001, 1, 0);
    step(1, 1, 16'h0002, 1, 0);
    step(1, 1, 16'h0003, 1, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);

    // Saturation and clear
    step(1, 1, 16'h7777, 0, 0);
    repeat (20) step(1, 1, 16'h8888, 0, 0);
    chk("sat_cnt", 32'(cnt0), 32'd15);
    step(1, 0, 16'h0, 0, 1);
    chk("clr_cnt", 32'(cnt1), 32'd0);
    chk("clr_err", 32'(er1), 32'd0);
    step(1, 1, 16'h9999, 0, 1);
    chk("clrdrop_cnt", 32'(cnt0), 32'd1);
    chk("clrdrop_err", 32'(er0), 32'd1);

    // Reset while holding a word
    step(0, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(1) == 1), 16'($urandom),
           ($urandom_range(9) < 6), ($urandom_range(19) == 0));
    end
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);
    @(negedge clkb);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_pulse_rx.md
# sync_pulse_rx

Receive-side stage that consumes the synchronized pulse produced by the toggle-to-pulse synchronizer in the clkb domain. When a pulse arrives, it captures a quasi-static data bus launched from the clka domain. The bus is held stable by the sender until acknowledged. The captured word is presented on a valid/ready interface, and a one-cycle acknowledge pulse is returned for the return-path toggle synchronizer. Protocol violations (pulses that cannot be accepted) are counted and flagged.

## Interface
- DATA_W, 16, width of captured data bus
- RESET_VAL, 'h0, reset value of out_data
- ACK_MODE, 0, 0 = ack on downstream transfer, 1 = ack on capture
- DROP_W, 4, width of saturating dropped-pulse counter

Ports:
- clkb  in  1  clock; all logic on rising edge
- clkb_rst_n  in  1  reset; asynchronous assert, active-low, deassert synchronous to clkb
- p_in  in  1  one-cycle event pulse (synchronizer output)
- d_in  in  DATA_W  cross-domain data, stable from before p_in until ack seen by sender
- out_data  out  DATA_W  captured word, registered
- out_valid  out  1  captured word available
- out_ready  in  1  downstream accepts when out_valid & out_ready at an edge
- ack_t  out  1  one-cycle ack pulse, feeds t of return toggle synchronizer
- err  out  1  sticky protocol-error flag
- err_clr  in  1  clears err and drop_cnt
- drop_cnt  out  DROP_W  count of dropped pulses, saturates at all-ones

## Operation
- Reset values: out_data = RESET_VAL; out_valid = 0; ack_t = 0; err = 0; drop_cnt = 0; state IDLE.
- All outputs are registered. No combinational path exists from inputs to outputs.
- State machine:
  - IDLE: out_valid = 0.
    - p_in = 1 → capture d_in into out_data → FULL.
    - ACK_MODE=1: ack_t = 1 the next cycle.
  - FULL: out_valid = 1.
    - Transfer (out_ready = 1), p_in = 0 → IDLE. ACK_MODE=0: ack_t = 1 the next cycle.
    - Transfer and p_in = 1 at the same edge → capture new d_in, stay FULL.
      - ACK_MODE=0: one ack_t pulse, for the transferred word.
      - ACK_MODE=1: one ack_t pulse, for the new capture.
      - Never two pulses.
    - No transfer, p_in = 1 → pulse dropped: out_data unchanged, err set, drop_cnt incremented (saturating), no ack_t.
    - No transfer, p_in = 0 → hold out_data and out_valid.
- ack_t is high for exactly one cycle per accepted word. Consecutive acks may occur on consecutive cycles.
- err_clr:
  - Clears err and drop_cnt at the next edge.
  - If a drop occurs at the same edge, the drop wins: err = 1, drop_cnt = 1.
- out_data changes only on capture. It is never altered by transfer or drop.
- Reset mid-operation discards any held word, with no ack. The sender's pending request is recovered by its own reset.

## Timing
- Capture latency: p_in high at edge k → out_valid = 1 and out_data = d_in(k) after edge k.
- Back-to-back throughput: one word per cycle when out_ready is held at 1.
- Transfer: out_valid & out_ready at edge m → out_valid = 0 after edge m, unless a new capture occurs at m.
- ACK_MODE=0: ack_t = 1 during the cycle after transfer edge m.
- ACK_MODE=1: ack_t = 1 during the cycle after capture edge k.
- out_valid never drops without a transfer, except on reset.
- err / drop_cnt update in the cycle after the dropping edge.

## Test plan
- Reset with p_in = 1 held → all outputs at reset values while clkb_rst_n = 0; capture after release only on a p_in edge sample.
- ACK_MODE=0, single event:
  - Stimulus: d_in = 16'hA5C3, p_in at edge 10, out_ready rises at edge 14.
  - Required: out_valid = 1 for edges 10–14, out_data = A5C3, ack_t = 1 only in the cycle after edge 14.
- ACK_MODE=1, same stimulus → ack_t = 1 only in the cycle after edge 10; no ack at transfer.
- Drop:
  - Stimulus: p_in at edge 5 with data 16'h1111, p_in at edge 7 with data 16'h2222, out_ready = 0.
  - Required: out_data stays 1111, err = 1, drop_cnt = 1, exactly one ack overall.
- Simultaneous transfer and capture: out_ready = 1 continuously, p_in on 3 consecutive edges with data 1, 2, 3 → out_data = 1, 2, 3 on consecutive cycles, out_valid continuously 1, 3 ack pulses, err = 0.
- Saturation and clear, DROP_W=4:
  - Stimulus: 20 drops, then err_clr.
  - Required: drop_cnt = 15 after the drops; err_clr → 0, err = 0; err_clr together with a drop → drop_cnt = 1, err = 1.
